// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: reads one assembled frame out of the assembler buffer and streams it downstream.
// Latency: first out_valid 2 cycles after entering STREAM, then 1 sample/cycle while out_ready stays high.
// Backpressure: out_ready low throttles read issue; a 2-entry skid FIFO absorbs the in-flight read, nothing dropped.
//
// Optional feature: define FRAME_TX_STATS_EN to add frame_cnt (16b, wraps) and abort_cnt (8b, saturates).
// Ports: clk/rst (async active-high); enable, abort, buf_full control inputs; buf_dout/read_ptr assembler
//        read port (1-cycle read latency); tx_done release pulse; out_data/out_valid/out_ready/out_sof/out_eof
//        downstream stream; busy = not idle.
module frame_tx_scheduler #(
    parameter int DATA_W     = 8,
    parameter int PTR_W      = 10,
    parameter int FRAME_LEN  = 992,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              abort,
    input  logic              buf_full,
    input  logic [DATA_W-1:0] buf_dout,
    output logic [PTR_W-1:0]  read_ptr,
    output logic              tx_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy
`ifdef FRAME_TX_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        abort_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FULL, S_STREAM, S_DRAIN, S_DONE, S_GAP
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eof;
    } entry_t;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FRAME_LEN - 1);
    localparam logic [15:0]      GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             infl_q, infl_d;
    logic             infl_sof_q, infl_sof_d;
    logic             infl_eof_q, infl_eof_d;
    entry_t [1:0]     fifo_q, fifo_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [15:0]      gap_q, gap_d;
    logic             aborted_q, aborted_d;

    logic             pop, push, kill, issue;
    logic [2:0]       occ;

    always_comb begin
        // Occupancy once this cycle's pop has left, counting the read still in flight.
        pop   = (cnt_q != 2'd0) && out_ready;
        occ   = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};

        // Abort, or the buffer vanishing under us, kills the frame.
        kill = 1'b0;
        case (state_q)
            S_WAIT_FULL:       kill = abort;
            S_STREAM, S_DRAIN: kill = abort || !buf_full;
            default:           kill = 1'b0;
        endcase

        issue = (state_q == S_STREAM) && !kill && (occ <= 3'd1);
        push  = infl_q && !kill;

        state_d    = state_q;
        ptr_d      = ptr_q;
        infl_d     = issue;
        infl_sof_d = issue && (ptr_q == '0);
        infl_eof_d = issue && (ptr_q == PTR_LAST);
        fifo_d     = fifo_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        gap_d      = gap_q;
        aborted_d  = aborted_q;

        if (push) begin
            fifo_d[wr_q] = '{data: buf_dout, sof: infl_sof_q, eof: infl_eof_q};
            wr_d         = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        if (kill) begin
            cnt_d = 2'd0;
            wr_d  = 1'b0;
            rd_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT_FULL;
            end
            S_WAIT_FULL: begin
                if (kill) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (buf_full) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (kill) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (issue) begin
                    // Pointer parks on the last address; it is rewound in DONE.
                    if (ptr_q == PTR_LAST) state_d = S_DRAIN;
                    else                   ptr_d   = ptr_q + PTR_W'(1);
                end
            end
            S_DRAIN: begin
                if (kill) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (occ == 3'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d     = '0;
                gap_d     = '0;
                aborted_d = 1'b0;
                if (GAP_CYCLES > 0) state_d = S_GAP;
                else                state_d = enable ? S_WAIT_FULL : S_IDLE;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = enable ? S_WAIT_FULL : S_IDLE;
                else                   gap_d   = gap_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            infl_q     <= 1'b0;
            infl_sof_q <= 1'b0;
            infl_eof_q <= 1'b0;
            fifo_q     <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            cnt_q      <= 2'd0;
            gap_q      <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            infl_q     <= infl_d;
            infl_sof_q <= infl_sof_d;
            infl_eof_q <= infl_eof_d;
            fifo_q     <= fifo_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            aborted_q  <= aborted_d;
        end
    end

    assign read_ptr  = ptr_q;
    assign tx_done   = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = fifo_q[rd_q].data;
    assign out_sof   = fifo_q[rd_q].sof;
    assign out_eof   = fifo_q[rd_q].eof;

`ifdef FRAME_TX_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  abort_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else if (state_q == S_DONE) begin
            if (aborted_q) begin
                if (abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
            end else begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign abort_cnt = abort_cnt_q;
`endif

endmodule
